// File: rtl/mmc_pkg.sv
// mmc_pkg: shared types for the multi-mode counter game block.
// Counting modes, last-game result codes and the scoring state encoding,
// plus small decode helpers for the counting mode.
package mmc_pkg;

   typedef enum logic [1:0] {
      UP1 = 2'b00,
      UPN = 2'b01,
      DN1 = 2'b10,
      DNN = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      NONE   = 2'b00,
      LOSER  = 2'b01,
      WINNER = 2'b10
   } who_e;

   typedef enum logic {
      PLAY = 1'b0,
      END  = 1'b1
   } score_state_e;

   // True when the mode counts downwards.
   function automatic logic mode_is_down(input mode_e m);
      return (m == DN1) || (m == DNN);
   endfunction

   // True when the mode uses the large step.
   function automatic logic mode_is_big(input mode_e m);
      return (m == UPN) || (m == DNN);
   endfunction

endpackage

// File: rtl/mmc_score_keeper.sv
// mmc_score_keeper: win/lose score registers, game-over detection and the
// PLAY/END scoring state machine. A score register holding SCORE_MAX
// triggers the game-over cycle on the next edge: gameover is raised, who is
// latched and both scores clear (any simultaneous event is dropped).
// Optional feature macro: MMC_STICKY_GAMEOVER_EN keeps the block in END
// (gameover held high) until a load exits it; otherwise END lasts one cycle.
module mmc_score_keeper
   import mmc_pkg::*;
#(
   parameter int SCORE_MAX = 15,
   parameter int SCORE_W   = $clog2(SCORE_MAX + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               win_ev_i,
   input  logic               lose_ev_i,
`ifdef MMC_STICKY_GAMEOVER_EN
   input  logic               load_i,
`endif
   output logic [SCORE_W-1:0] winner_cnt_o,
   output logic [SCORE_W-1:0] loser_cnt_o,
   output logic [1:0]         who_o,
   output logic               gameover_o,
   output logic               state_o
);

   localparam logic [SCORE_W-1:0] MAX_S = SCORE_W'(SCORE_MAX);
   localparam logic [SCORE_W-1:0] ONE_S = SCORE_W'(1);

   score_state_e       state_q;
   logic [SCORE_W-1:0] winner_q;
   logic [SCORE_W-1:0] loser_q;
   who_e               who_q;
   logic               gameover_q;

   // Scoring FSM: counts events in PLAY, runs the game-over cycle in END.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= PLAY;
         winner_q   <= '0;
         loser_q    <= '0;
         who_q      <= NONE;
         gameover_q <= 1'b0;
      end else begin
         case (state_q)
            PLAY: begin
               if ((winner_q == MAX_S) || (loser_q == MAX_S)) begin
                  state_q    <= END;
                  gameover_q <= 1'b1;
                  who_q      <= (winner_q == MAX_S) ? WINNER : LOSER;
                  winner_q   <= '0;
                  loser_q    <= '0;
               end else begin
                  gameover_q <= 1'b0;
                  if (win_ev_i)  winner_q <= winner_q + ONE_S;
                  if (lose_ev_i) loser_q  <= loser_q + ONE_S;
               end
            end
            END: begin
`ifdef MMC_STICKY_GAMEOVER_EN
               // Counter is frozen here, so no events can arrive.
               if (load_i) begin
                  state_q    <= PLAY;
                  gameover_q <= 1'b0;
               end
`else
               state_q    <= PLAY;
               gameover_q <= 1'b0;
               if (win_ev_i)  winner_q <= winner_q + ONE_S;
               if (lose_ev_i) loser_q  <= loser_q + ONE_S;
`endif
            end
            default: begin
               state_q    <= PLAY;
               gameover_q <= 1'b0;
            end
         endcase
      end
   end

   assign winner_cnt_o = winner_q;
   assign loser_cnt_o  = loser_q;
   assign who_o        = who_q;
   assign gameover_o   = gameover_q;
   assign state_o      = state_q;

endmodule

// File: rtl/mult_mode_counter_gen.sv
// mult_mode_counter_gen: parametrised up/down counter (step 1 or STEP_BIG,
// modulo 2^WIDTH) with load and enable, feeding win/lose events into the
// score keeper. An event fires when a counting step lands on all-ones
// (win) or all-zeros (lose); loads never score.
// Optional feature macro: MMC_STICKY_GAMEOVER_EN freezes the counter while
// the score keeper sits in END; only a load (or reset) releases it.
// dbg_state_o exposes the scoring state (0 PLAY, 1 END).
module mult_mode_counter_gen
   import mmc_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int STEP_BIG  = 2,
   parameter int SCORE_MAX = 15,
   parameter int SCORE_W   = $clog2(SCORE_MAX + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cnt_en,
   input  logic [1:0]         ctrl,
   input  logic               init_load,
   input  logic [WIDTH-1:0]   init_value,
   output logic [WIDTH-1:0]   counter,
   output logic [SCORE_W-1:0] winner_cnt,
   output logic [SCORE_W-1:0] loser_cnt,
   output logic [1:0]         who,
   output logic               gameover,
   output logic               dbg_state_o
);

   mode_e            mode;
   logic [WIDTH-1:0] step_w;
   logic [WIDTH-1:0] cnt_step;
   logic             frozen;
   logic             counting;
   logic             win_ev;
   logic             lose_ev;
   logic [WIDTH-1:0] counter_q;
   logic [WIDTH-1:0] counter_d;
   logic             state;

   assign mode     = mode_e'(ctrl);
   assign step_w   = mode_is_big(mode) ? WIDTH'(STEP_BIG) : WIDTH'(1);
   assign cnt_step = mode_is_down(mode) ? (counter_q - step_w) : (counter_q + step_w);

`ifdef MMC_STICKY_GAMEOVER_EN
   assign frozen = (state == END);
`else
   assign frozen = 1'b0;
`endif

   assign counting = cnt_en & ~init_load & ~frozen;
   assign win_ev   = counting & (cnt_step == {WIDTH{1'b1}});
   assign lose_ev  = counting & (cnt_step == {WIDTH{1'b0}});

   // Next count: load beats counting, counting beats hold.
   always_comb begin
      counter_d = counter_q;
      if (init_load)     counter_d = init_value;
      else if (counting) counter_d = cnt_step;
   end

   // Counter register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) counter_q <= '0;
      else      counter_q <= counter_d;
   end

   mmc_score_keeper #(
      .SCORE_MAX (SCORE_MAX),
      .SCORE_W   (SCORE_W)
   ) u_score (
      .clk          (clk),
      .rst          (rst),
      .win_ev_i     (win_ev),
      .lose_ev_i    (lose_ev),
`ifdef MMC_STICKY_GAMEOVER_EN
      .load_i       (init_load),
`endif
      .winner_cnt_o (winner_cnt),
      .loser_cnt_o  (loser_cnt),
      .who_o        (who),
      .gameover_o   (gameover),
      .state_o      (state)
   );

   assign counter     = counter_q;
   assign dbg_state_o = state;

endmodule

// File: tb/tb_mult_mode_counter_gen.sv
// Bench for mult_mode_counter_gen at default parameters (WIDTH=4,
// STEP_BIG=2, SCORE_MAX=15). Every cycle is compared against a behavioural
// game model; directed scenarios add fixed-value checks at key points.
module tb_mult_mode_counter_gen;
   localparam int W     = 4;
   localparam int STEP  = 2;
   localparam int MAX   = 15;
   localparam int SW    = $clog2(MAX + 1);
   localparam int MOD   = 1 << W;
`ifdef MMC_STICKY_GAMEOVER_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cnt_en = 1'b0;
   logic [1:0]    ctrl = 2'b00;
   logic          init_load = 1'b0;
   logic [W-1:0]  init_value = '0;
   logic [W-1:0]  counter;
   logic [SW-1:0] winner_cnt;
   logic [SW-1:0] loser_cnt;
   logic [1:0]    who;
   logic          gameover;
   logic          dbg_state_o;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   int m_cnt = 0, m_win = 0, m_lose = 0, m_who = 0, m_go = 0;
   bit m_end = 1'b0;
   int go_seen = 0;

   mult_mode_counter_gen #(
      .WIDTH(W), .STEP_BIG(STEP), .SCORE_MAX(MAX)
   ) dut (
      .clk(clk), .rst(rst), .cnt_en(cnt_en), .ctrl(ctrl),
      .init_load(init_load), .init_value(init_value),
      .counter(counter), .winner_cnt(winner_cnt), .loser_cnt(loser_cnt),
      .who(who), .gameover(gameover), .dbg_state_o(dbg_state_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      else n_pass++;
   endtask

   // Game rules applied to one clock edge with the given inputs.
   task automatic model_step(input bit r, input bit en, input bit [1:0] c, input bit ld, input int v);
      bit counted = 1'b0;
      bit trig;
      if (!r) begin
         m_cnt = 0; m_win = 0; m_lose = 0; m_who = 0; m_go = 0; m_end = 1'b0;
         return;
      end
      trig = (m_win == MAX) || (m_lose == MAX);
      if (ld) m_cnt = v;
      else if (en && !(STICKY && m_end)) begin
         int d;
         d = c[0] ? STEP : 1;
         m_cnt = c[1] ? (m_cnt - d + MOD) % MOD : (m_cnt + d) % MOD;
         counted = 1'b1;
      end
      if (trig) begin
         m_who = (m_win == MAX) ? 2 : 1;
         m_win = 0; m_lose = 0; m_go = 1; m_end = 1'b1;
      end else if (STICKY && m_end) begin
         if (ld) begin m_end = 1'b0; m_go = 0; end
      end else begin
         m_go = 0; m_end = 1'b0;
         if (counted && m_cnt == MOD - 1) m_win++;
         if (counted && m_cnt == 0)       m_lose++;
      end
   endtask

   task automatic check_all();
      check("counter",    counter,     m_cnt);
      check("winner_cnt", winner_cnt,  m_win);
      check("loser_cnt",  loser_cnt,   m_lose);
      check("who",        who,         m_who);
      check("gameover",   gameover,    m_go);
      check("state",      dbg_state_o, m_end);
   endtask

   // Drive one cycle, advance the model, then compare after the edge.
   task automatic cyc(input bit r, input bit en, input bit [1:0] c, input bit ld, input int v);
      rst = r; cnt_en = en; ctrl = c; init_load = ld; init_value = W'(v);
      @(posedge clk);
      model_step(r, en, c, ld, v);
      #1;
      if (gameover === 1'b1) go_seen++;
      check_all();
   endtask

   initial begin
      // reset while a load of all-ones is requested
      cyc(0, 1, 2'b00, 1, 15);
      cyc(0, 1, 2'b00, 1, 15);
      check("rst_counter", counter, 0);

      // up by 1 from 0
      cyc(1, 0, 2'b00, 1, 0);
      for (int i = 0; i < 15; i++) cyc(1, 1, 2'b00, 0, 0);
      check("up1_top", counter, 15);
      check("up1_win", winner_cnt, 1);
      cyc(1, 1, 2'b00, 0, 0);
      check("up1_wrap", counter, 0);
      check("up1_lose", loser_cnt, 1);

      // down by 2 from all-ones
      cyc(1, 0, 2'b11, 1, 15);
      for (int i = 0; i < 8; i++) cyc(1, 1, 2'b11, 0, 0);
      check("dn2_wrap", counter, 15);
      check("dn2_win", winner_cnt, 2);
      check("dn2_lose", loser_cnt, 1);

      // enable low holds, held load never scores
      for (int i = 0; i < 5; i++) cyc(1, 0, 2'b00, 0, 0);
      check("hold_counter", counter, 15);
      for (int i = 0; i < 3; i++) cyc(1, 1, 2'b00, 1, 0);
      check("held_load_win", winner_cnt, 2);
      check("held_load_lose", loser_cnt, 1);

      // up by 2 from odd value until a winner game over
      cyc(0, 0, 2'b00, 0, 0);
      cyc(1, 0, 2'b01, 1, 3);
      go_seen = 0;
      for (int i = 0; i < 125; i++) cyc(1, 1, 2'b01, 0, 0);
      check("up2_who", who, 2);
      check("up2_go_cycles", go_seen, STICKY ? 7 : 1);
      check("up2_win_cleared", winner_cnt, 0);
      if (STICKY) begin
         for (int i = 0; i < 20; i++) cyc(1, 1, 2'b00, 0, 0);
         check("sticky_frozen", counter, 1);
         check("sticky_go", gameover, 1);
         cyc(1, 1, 2'b00, 1, 5);
         check("sticky_load", counter, 5);
         check("sticky_go_drop", gameover, 0);
         cyc(1, 1, 2'b00, 0, 0);
         check("sticky_resume", counter, 6);
      end

      // down by 1 from 0: winner reaches the limit first
      cyc(0, 0, 2'b00, 0, 0);
      cyc(1, 0, 2'b10, 1, 0);
      cyc(1, 1, 2'b10, 0, 0);
      check("dn1_first", counter, 15);
      check("dn1_first_win", winner_cnt, 1);
      for (int i = 0; i < 230; i++) cyc(1, 1, 2'b10, 0, 0);
      check("dn1_who", who, 2);

      // randomized traffic, mode held for random runs
      cyc(0, 0, 2'b00, 0, 0);
      begin
         int run = 0;
         bit [1:0] c = 2'b00;
         for (int i = 0; i < 4000; i++) begin
            if (run == 0) begin
               c   = 2'($urandom_range(0, 3));
               run = $urandom_range(5, 80);
            end
            run--;
            cyc($urandom_range(0, 999) != 0, $urandom_range(0, 9) != 0, c,
                $urandom_range(0, 59) == 0, $urandom_range(0, MOD - 1));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
